// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the display register bank and its write
// arbiter.
//   state_e    : arbiter FSM states (IDLE, WRITE, ERR_WR)
//   *_ADDR     : register bank addresses of each display field
//   NUM_REGS   : number of implemented registers; addresses at or above this
//                are rejected by the arbiter
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    ERR_WR = 2'd2
  } state_e;

  localparam int SPEED_ADDR     = 0;
  localparam int RTD_ADDR       = 1;
  localparam int CAR_BATT_ADDR  = 2;
  localparam int DISP_BATT_ADDR = 3;
  localparam int GPS_ADDR       = 4;
  localparam int ERR_ADDR       = 5;
  localparam int NUM_REGS       = 6;

endpackage

// File: rtl/display_reg_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches for the first asserted request
// starting one position after the previous grant, wrapping modulo NUM_REQ.
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    index granted most recently
//   valid      out 1        at least one request asserted
//   grant      out IDX_W    selected source index (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   grant
);

  // Offsets 1..NUM_REQ visit every source once, with last_grant itself last,
  // so a lone requester is still served back to back.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/display_reg_arbiter.sv
// -----------------------------------------------------------------------------
// display_reg_arbiter
// Round-robin write arbiter in front of the display register bank. Serialises
// writes from NUM_REQ sources onto the bank's single addr/write/data port,
// acks each consumed request and flags out-of-range addresses.
// Optional feature macro: DISPLAY_STALE_TIMEOUT_EN adds a per-source staleness
// watchdog that writes ERR_STALE|i to the error register when source i has not
// been acked for TIMEOUT_CYC cycles.
//   clk, reset  clock, synchronous active-high reset
//   req         per-source request, held with addr/data until ack
//   req_addr    packed per-source addresses (source i at [i*ADDR_W +: ADDR_W])
//   req_data    packed per-source data     (source i at [i*DATA_W +: DATA_W])
//   ack         one-cycle pulse per source: request consumed
//   addr        register bank address
//   write       register bank write strobe
//   data_out    register bank write data
//   busy        FSM not in IDLE
//   bad_addr    one-cycle pulse: acked request addressed a missing register
//   stale       per-source stale flags (zero without the macro)
// -----------------------------------------------------------------------------
module display_reg_arbiter
  import display_pkg::*;
#(
  parameter int                NUM_REQ     = 4,
  parameter int                ADDR_W      = 3,
  parameter int                DATA_W      = 8,
  parameter int                TIMEOUT_CYC = 50_000_000,
  parameter logic [DATA_W-1:0] ERR_STALE   = DATA_W'(8'hE0)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [ADDR_W-1:0]         addr,
  output logic                      write,
  output logic [DATA_W-1:0]         data_out,
  output logic                      busy,
  output logic                      bad_addr,
  output logic [NUM_REQ-1:0]        stale
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 write_q, write_d;
  logic                 bad_addr_q, bad_addr_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [ADDR_W-1:0]    src_addr [NUM_REQ];
  logic [DATA_W-1:0]    src_data [NUM_REQ];

  logic                 err_valid;
  logic [IDX_W-1:0]     err_idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      src_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
      src_data[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_idx)
  );

`ifdef DISPLAY_STALE_TIMEOUT_EN
  localparam int              CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0] stale_q, stale_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;

  // Lowest pending index gets the error register first.
  always_comb begin
    err_valid = 1'b0;
    err_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        err_valid = 1'b1;
        err_idx   = IDX_W'(i);
      end
    end
  end

  // Counters saturate, so the TIMEOUT edge is seen once per stale episode and
  // only one error write is queued until the source is acked again.
  always_comb begin
    stale_d = stale_q;
    pend_d  = pend_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ack_q[i]) begin
        cnt_d[i]   = '0;
        stale_d[i] = 1'b0;
      end else if (cnt_q[i] != CNT_TO) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (cnt_d[i] == CNT_TO) begin
          stale_d[i] = 1'b1;
          pend_d[i]  = 1'b1;
        end
      end
    end
    if (state_q == IDLE && err_valid) begin
      pend_d[err_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stale_q <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      stale_q <= stale_d;
      pend_q  <= pend_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stale = stale_q;
`else
  logic unused_stale_cfg;

  assign err_valid        = 1'b0;
  assign err_idx          = '0;
  assign stale            = '0;
  assign unused_stale_cfg = ^{ERR_STALE, 32'(TIMEOUT_CYC), 32'(ERR_ADDR)};
`endif

  // Strobes are decided on the IDLE->WRITE/ERR_WR edge so they are registered
  // yet still appear in the cycle after the request was sampled.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    write_d      = 1'b0;
    ack_d        = '0;
    bad_addr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef DISPLAY_STALE_TIMEOUT_EN
        if (err_valid) begin
          state_d = ERR_WR;
          addr_d  = ADDR_W'(ERR_ADDR);
          data_d  = ERR_STALE | DATA_W'(err_idx);
          write_d = 1'b1;
        end else
`endif
        if (pick_valid) begin
          state_d         = WRITE;
          gnt_d           = pick_idx;
          addr_d          = src_addr[pick_idx];
          data_d          = src_data[pick_idx];
          ack_d[pick_idx] = 1'b1;
          if (32'(src_addr[pick_idx]) >= 32'(NUM_REGS)) begin
            bad_addr_d = 1'b1;
          end else begin
            write_d = 1'b1;
          end
        end
      end
      WRITE: begin
        last_grant_d = gnt_q;
        state_d      = IDLE;
      end
      ERR_WR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      ack_q        <= '0;
      bad_addr_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      write_q      <= write_d;
      ack_q        <= ack_d;
      bad_addr_q   <= bad_addr_d;
      busy_q       <= busy_d;
    end
  end

  // A reset arriving mid-transfer must not let the bank or a source see a
  // strobe, so the registered pulses are masked by reset within that cycle.
  assign write    = write_q & ~reset;
  assign ack      = ack_q & {NUM_REQ{~reset}};
  assign bad_addr = bad_addr_q & ~reset;
  assign addr     = addr_q;
  assign data_out = data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_display_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_reg_arbiter
// Directed bench for display_reg_arbiter. Expected bank transactions are queued
// as stimulus is driven and a monitor pops and compares them whenever the DUT
// strobes write, bad_addr or ack.
// -----------------------------------------------------------------------------
module tb_display_reg_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;

  typedef struct packed {
    logic [NUM_REQ-1:0] ack;
    logic               write;
    logic               bad;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } exp_t;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [ADDR_W-1:0]         addr;
  logic                      write;
  logic [DATA_W-1:0]         data_out;
  logic                      busy;
  logic                      bad_addr;
  logic [NUM_REQ-1:0]        stale;

  exp_t exp_q[$];
  exp_t mon_obs;
  exp_t mon_exp;
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   sb_en        = 1'b1;
  int   err_count    = 0;
  bit   err_seen     = 1'b0;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] err_data;

  display_reg_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (16),
    .ERR_STALE   (8'hE0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .addr     (addr),
    .write    (write),
    .data_out (data_out),
    .busy     (busy),
    .bad_addr (bad_addr),
    .stale    (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int src, input logic en, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d);
    req[src]                     = en;
    req_addr[src*ADDR_W +: ADDR_W] = a;
    req_data[src*DATA_W +: DATA_W] = d;
  endtask

  task automatic expectTxn(input logic [NUM_REQ-1:0] a, input logic w, input logic b,
                           input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
    exp_t e;
    e.ack   = a;
    e.write = w;
    e.bad   = b;
    e.addr  = ad;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every bank/ack strobe must match the oldest expectation.
  always begin
    @(negedge clk);
    #3;
`ifdef DISPLAY_STALE_TIMEOUT_EN
    if (write && ack == '0) begin
      err_seen = 1'b1;
      err_addr = addr;
      err_data = data_out;
      err_count++;
    end else
`endif
    if (sb_en && (write || bad_addr || ack != '0)) begin
      mon_obs = {ack, write, bad_addr, addr, data_out};
      checkOutput("sb expected entry", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        checkOutput("sb txn", 32'(mon_obs), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;

    // Reset state
    step();
    step();
    #2;
    checkOutput("reset ack", 32'(ack), 32'(0));
    checkOutput("reset write", 32'(write), 32'(0));
    checkOutput("reset addr", 32'(addr), 32'(0));
    checkOutput("reset data_out", 32'(data_out), 32'(0));
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset bad_addr", 32'(bad_addr), 32'(0));
    checkOutput("reset stale", 32'(stale), 32'(0));
    reset = 1'b0;

    // Test 1: single write, one-cycle latency
    step();
    applyStimulus(0, 1'b1, 3'd0, 8'd42);
    expectTxn(4'b0001, 1'b1, 1'b0, 3'd0, 8'd42);
    step();
    #2;
    checkOutput("t1 latency write", 32'(write), 32'(1));
    checkOutput("t1 latency ack", 32'(ack), 32'(4'b0001));
    applyStimulus(0, 1'b0, 3'd0, 8'd42);
    step();

    // Test 2: two sources held, alternating grants, busy toggling
    doReset();
    applyStimulus(0, 1'b1, 3'd1, 8'h11);
    applyStimulus(1, 1'b1, 3'd2, 8'h22);
    expectTxn(4'b0001, 1'b1, 1'b0, 3'd1, 8'h11);
    expectTxn(4'b0010, 1'b1, 1'b0, 3'd2, 8'h22);
    expectTxn(4'b0001, 1'b1, 1'b0, 3'd1, 8'h33);
    expectTxn(4'b0010, 1'b1, 1'b0, 3'd2, 8'h22);
    for (int k = 1; k <= 7; k++) begin
      step();
      #2;
      checkOutput($sformatf("t2 busy cyc%0d", k), 32'(busy), 32'(k % 2));
      if (k == 1) applyStimulus(0, 1'b1, 3'd1, 8'h33);
    end
    applyStimulus(0, 1'b0, 3'd1, 8'h33);
    applyStimulus(1, 1'b0, 3'd2, 8'h22);

    // Test 3: out-of-range address and address boundaries
    step();
    applyStimulus(3, 1'b1, 3'd7, 8'hFF);
    expectTxn(4'b1000, 1'b0, 1'b1, 3'd7, 8'hFF);
    step();
    #2;
    checkOutput("t3 bad_addr", 32'(bad_addr), 32'(1));
    checkOutput("t3 no write", 32'(write), 32'(0));
    applyStimulus(3, 1'b0, 3'd7, 8'hFF);
    step();
    #2;
    checkOutput("t3 bad_addr one cycle", 32'(bad_addr), 32'(0));
    checkOutput("t3 addr hold", 32'(addr), 32'(7));
    checkOutput("t3 data hold", 32'(data_out), 32'(8'hFF));
    applyStimulus(1, 1'b1, 3'd5, 8'h55);
    expectTxn(4'b0010, 1'b1, 1'b0, 3'd5, 8'h55);
    step();
    #2;
    applyStimulus(1, 1'b0, 3'd5, 8'h55);
    step();
    applyStimulus(2, 1'b1, 3'd6, 8'h66);
    expectTxn(4'b0100, 1'b0, 1'b1, 3'd6, 8'h66);
    step();
    #2;
    applyStimulus(2, 1'b0, 3'd6, 8'h66);
    step();

    // Test 4: reset during the WRITE cycle of a source 2 transfer
    applyStimulus(2, 1'b1, 3'd4, 8'h77);
    step();
    reset = 1'b1;
    applyStimulus(2, 1'b0, 3'd4, 8'h77);
    #2;
    checkOutput("t4 write suppressed", 32'(write), 32'(0));
    checkOutput("t4 ack suppressed", 32'(ack), 32'(0));
    step();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 3'd0, 8'h0A);
    applyStimulus(3, 1'b1, 3'd3, 8'h3B);
    expectTxn(4'b0001, 1'b1, 1'b0, 3'd0, 8'h0A);
    expectTxn(4'b1000, 1'b1, 1'b0, 3'd3, 8'h3B);
    step();
    #2;
    checkOutput("t4 first grant after reset", 32'(ack), 32'(4'b0001));
    applyStimulus(0, 1'b0, 3'd0, 8'h0A);
    step();
    step();
    #2;
    checkOutput("t4 second grant", 32'(ack), 32'(4'b1000));
    applyStimulus(3, 1'b0, 3'd3, 8'h3B);
    step();
    step();
    checkOutput("t4 queue drained", 32'(exp_q.size()), 32'(0));

`ifdef DISPLAY_STALE_TIMEOUT_EN
    // Test 5: source 2 silent while 0,1,3 keep being served
    sb_en = 1'b0;
    doReset();
    err_seen  = 1'b0;
    err_count = 0;
    applyStimulus(0, 1'b1, 3'd0, 8'h01);
    applyStimulus(1, 1'b1, 3'd1, 8'h02);
    applyStimulus(3, 1'b1, 3'd3, 8'h03);
    for (int k = 0; k < 80 && !err_seen; k++) begin
      step();
      #4;
    end
    checkOutput("t5 err write seen", 32'(err_seen), 32'(1));
    checkOutput("t5 err addr", 32'(err_addr), 32'(5));
    checkOutput("t5 err data", 32'(err_data), 32'(8'hE2));
    checkOutput("t5 stale", 32'(stale), 32'(4'b0100));
    applyStimulus(0, 1'b0, 3'd0, 8'h01);
    applyStimulus(1, 1'b0, 3'd1, 8'h02);
    applyStimulus(3, 1'b0, 3'd3, 8'h03);
    step();
    step();
    applyStimulus(2, 1'b1, 3'd4, 8'h09);
    begin
      bit got_ack;
      got_ack = 1'b0;
      for (int k = 0; k < 10 && !got_ack; k++) begin
        step();
        #2;
        if (ack[2]) got_ack = 1'b1;
      end
      checkOutput("t5 ack2 seen", 32'(got_ack), 32'(1));
    end
    applyStimulus(2, 1'b0, 3'd4, 8'h09);
    step();
    #2;
    checkOutput("t5 stale cleared", 32'(stale[2]), 32'(0));
    checkOutput("t5 single err write", 32'(err_count), 32'(1));
    sb_en = 1'b1;
`else
    // Test 6: long idle period produces no activity
    for (int k = 0; k < 1000; k++) begin
      step();
      #2;
      checkOutput("t6 idle quiet", 32'({write, bad_addr, ack, stale}), 32'(0));
    end
`endif

    step();
    step();
    checkOutput("final queue drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
